bram_portb_arbiter: RTL and testbench
=====================================

Name: bram_portb_arbiter

Overview:
- Shares the second BRAM port (addr_b/data_b/we_b/q_b) between two requesters: VGA scanout (read-only, high priority) and an auxiliary master (read/write, e.g. sprite/DMA loader).
- Fixed-priority arbitration with an anti-starvation counter, registered BRAM drive, fixed read latency, and a saturating VGA-miss counter for debug on the seven-segment display.

Parameters:
AW, 16, address width
DW, 16, data width
STARVE_LIMIT, 4, consecutive aux denials before aux is forced through (1..255)
MISS_W, 8, width of VGA miss counter

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
vga_req  in  1  VGA read request; held with vga_addr until granted
vga_addr  in  AW  VGA read address
vga_gnt  out  1  combinational grant, same cycle as request
vga_rvalid  out  1  read data valid pulse
vga_rdata  out  DW  read data, valid when vga_rvalid
aux_req  in  1  aux request; held with aux_we/addr/wdata until granted
aux_we  in  1  1=write, 0=read
aux_addr  in  AW  aux address
aux_wdata  in  DW  aux write data
aux_gnt  out  1  combinational grant
aux_rvalid  out  1  aux read data valid pulse (never for writes)
aux_rdata  out  DW  read data, valid when aux_rvalid
addr_b  out  AW  BRAM port-B address (registered)
data_b  out  DW  BRAM port-B write data (registered)
we_b  out  1  BRAM port-B write enable (registered)
q_b  in  DW  BRAM port-B read data (one-cycle synchronous read)
miss_clr  in  1  synchronous clear of miss_count
miss_count  out  MISS_W  saturating count of VGA request cycles denied

Behaviour:
- Reset (async, rst=1): addr_b=0, data_b=0, we_b=0, vga_rvalid=0, aux_rvalid=0, starve_cnt=0, miss_count=0, read-pipeline tags cleared; in-flight reads are dropped, with no rvalid after reset.
- starve = (starve_cnt == STARVE_LIMIT).
- vga_gnt = vga_req & ~(aux_req & starve).
- aux_gnt = aux_req & (~vga_req | starve).
- At most one grant per cycle. Requests are accepted on the clock edge where req&gnt=1.
- Accepted request at edge N: addr_b/data_b/we_b load at edge N. data_b and we_b come from aux_wdata/aux_we for aux; data_b holds its previous value and we_b=0 for VGA. BRAM samples at edge N+1. q_b is valid during cycle N+1 → N+2.
- Read pipeline: 2-stage tag shift {vga, aux}. The rvalid for the request accepted at edge N asserts for exactly one cycle, from edge N+1 to edge N+2. rdata is wired to q_b; both rdata outputs are valid only while their rvalid is high.
- Idle cycle (no grant): we_b=0 at the next edge; addr_b holds.
- Write: one-cycle we_b pulse, no rvalid. Back-to-back writes are allowed every cycle.
- Back-to-back reads: full throughput, one per cycle, in order; requesters may interleave freely.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each edge where aux_req=1 and aux_gnt=0.
  - Clears to 0 on aux acceptance or when aux_req=0.
  - Effect: after STARVE_LIMIT denied cycles, aux wins exactly one slot, then VGA priority resumes.
- miss_count:
  - Increments on each edge with vga_req=1 and vga_gnt=0, saturating at all-ones.
  - miss_clr=1 forces 0 and takes precedence over increment.
- Same-address read and write in adjacent slots: BRAM read-during-write is not relied on. A read accepted the cycle after a write to the same address returns the new data.
- Reset mid-operation: all pulses cease immediately. Requesters must re-issue.

Test Plan:
- Reset/idle: assert rst mid-stream with reads in flight → addr_b=0, we_b=0, no rvalid on either port in the following 3 cycles; miss_count=0.
- Single read each: VGA read 0x0040 accepted at edge N, BRAM preloaded 0x0040=0xBEEF → vga_rvalid=1 only in cycle N+1..N+2, vga_rdata=0xBEEF; aux read 0x0041=0x1234 behaves identically on the aux port.
- Aux write then read: aux write 0x0100←0xA5A5 (we_b pulse one cycle, data_b=0xA5A5), then aux read 0x0100 next cycle → aux_rvalid with 0xA5A5, no rvalid for the write.
- Contention/starvation (STARVE_LIMIT=4): vga_req continuous, aux_req raised at cycle 0 → aux denied cycles 0–3, aux_gnt=1 and vga_gnt=0 in cycle 4, VGA granted cycle 5 onward, miss_count=1, starve_cnt back to 0.
- Interleaved reads: alternate VGA/aux reads to addresses holding 0x0001..0x0008 → each rvalid is routed to the correct port, in order, with no drops or duplicates.
- Miss counter: force 300 denied VGA cycles (MISS_W=8) → miss_count saturates at 0xFF; miss_clr pulse while a denial occurs → 0x00.

Source files
------------

// File: rtl/bram_portb_arbiter.sv
// ---------------------------------------------------------------------------
// bram_portb_arbiter
//
// Shares port B of a dual-port block RAM between two requesters:
//   * VGA scanout: read-only, high priority.
//   * Aux master (sprite/DMA loader): read/write, low priority. An
//     anti-starvation counter forces one aux slot through after
//     STARVE_LIMIT consecutive denied cycles.
//
// The BRAM address/data/write-enable are driven from registers. Read data
// comes back on a fixed two-edge latency and is steered to the owning port
// by a small tag shift register. A saturating counter records VGA request
// cycles that were denied, for display on the seven-segment debug readout.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   vga_req/vga_addr              VGA read request (held until granted)
//   vga_gnt                       combinational VGA grant
//   vga_rvalid/vga_rdata          VGA read response (one-cycle pulse)
//   aux_req/aux_we/aux_addr/
//   aux_wdata                     aux request (held until granted)
//   aux_gnt                       combinational aux grant
//   aux_rvalid/aux_rdata          aux read response (never for writes)
//   addr_b/data_b/we_b            registered BRAM port-B drive
//   q_b                           BRAM port-B read data (1-cycle sync read)
//   miss_clr                      synchronous clear of miss_count
//   miss_count                    saturating count of denied VGA cycles
// ---------------------------------------------------------------------------
module bram_portb_arbiter #(
    parameter int AW           = 16,
    parameter int DW           = 16,
    parameter int STARVE_LIMIT = 4,
    parameter int MISS_W       = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              vga_req,
    input  logic [AW-1:0]     vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DW-1:0]     vga_rdata,

    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [AW-1:0]     aux_addr,
    input  logic [DW-1:0]     aux_wdata,
    output logic              aux_gnt,
    output logic              aux_rvalid,
    output logic [DW-1:0]     aux_rdata,

    output logic [AW-1:0]     addr_b,
    output logic [DW-1:0]     data_b,
    output logic              we_b,
    input  logic [DW-1:0]     q_b,

    input  logic              miss_clr,
    output logic [MISS_W-1:0] miss_count
);

    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    logic [7:0]        starve_cnt_reg;
    logic              starve;
    // Tag shift registers: bit 0 marks a read accepted at the last edge,
    // bit 1 marks the cycle in which q_b carries that read's data.
    logic [1:0]        vga_tag_reg;
    logic [1:0]        aux_tag_reg;
    logic [MISS_W-1:0] miss_count_reg;

    // ---------------------------------------------------------------------
    // Arbitration: VGA wins unless aux has been starved long enough.
    // ---------------------------------------------------------------------
    assign starve  = (starve_cnt_reg == STARVE_MAX);
    assign vga_gnt = vga_req & ~(aux_req & starve);
    assign aux_gnt = aux_req & (~vga_req | starve);

    // ---------------------------------------------------------------------
    // Registered BRAM drive. A VGA read leaves data_b untouched; an idle
    // cycle drops we_b and holds the address.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_b <= '0;
            data_b <= '0;
            we_b   <= 1'b0;
        end else begin
            we_b <= 1'b0;
            if (vga_gnt) begin
                addr_b <= vga_addr;
            end else if (aux_gnt) begin
                addr_b <= aux_addr;
                data_b <= aux_wdata;
                we_b   <= aux_we;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Read-return pipeline. BRAM samples addr_b one edge after acceptance,
    // so q_b is valid in the cycle after that; the tag reaches bit 1 then.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_tag_reg <= 2'b00;
            aux_tag_reg <= 2'b00;
        end else begin
            vga_tag_reg <= {vga_tag_reg[0], vga_gnt};
            aux_tag_reg <= {aux_tag_reg[0], aux_gnt & ~aux_we};
        end
    end

    assign vga_rvalid = vga_tag_reg[1];
    assign aux_rvalid = aux_tag_reg[1];
    assign vga_rdata  = q_b;
    assign aux_rdata  = q_b;

    // ---------------------------------------------------------------------
    // Anti-starvation counter: counts consecutive denied aux cycles and
    // restarts whenever aux is served or withdraws its request.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_reg <= 8'd0;
        end else if (aux_req && !aux_gnt) begin
            if (starve_cnt_reg != STARVE_MAX) begin
                starve_cnt_reg <= starve_cnt_reg + 8'd1;
            end
        end else begin
            starve_cnt_reg <= 8'd0;
        end
    end

    // ---------------------------------------------------------------------
    // VGA miss counter, saturating; clear wins over increment.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_count_reg <= '0;
        end else if (miss_clr) begin
            miss_count_reg <= '0;
        end else if (vga_req && !vga_gnt && (miss_count_reg != {MISS_W{1'b1}})) begin
            miss_count_reg <= miss_count_reg + 1'b1;
        end
    end

    assign miss_count = miss_count_reg;

endmodule

// File: tb/tb_bram_portb_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for bram_portb_arbiter.
// A behavioural BRAM drives q_b. A reference model keeps a shadow copy of
// memory contents as seen by accepted requests, predicts grants from the
// priority/starvation rules, and pushes expected read responses into a
// scoreboard queue; an independent monitor pops and compares them.
// ---------------------------------------------------------------------------
module tb_bram_portb_arbiter;

    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int LIMIT = 4;
    localparam int MW    = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          vga_req = 1'b0;
    logic [AW-1:0] vga_addr = '0;
    logic          vga_gnt, vga_rvalid;
    logic [DW-1:0] vga_rdata;
    logic          aux_req = 1'b0;
    logic          aux_we = 1'b0;
    logic [AW-1:0] aux_addr = '0;
    logic [DW-1:0] aux_wdata = '0;
    logic          aux_gnt, aux_rvalid;
    logic [DW-1:0] aux_rdata;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] data_b;
    logic          we_b;
    logic [DW-1:0] q_b = '0;
    logic          miss_clr = 1'b0;
    logic [MW-1:0] miss_count;

    bram_portb_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT), .MISS_W(MW)) dut (
        .clk(clk), .rst(rst),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
        .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr),
        .aux_wdata(aux_wdata), .aux_gnt(aux_gnt),
        .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
        .addr_b(addr_b), .data_b(data_b), .we_b(we_b), .q_b(q_b),
        .miss_clr(miss_clr), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // Behavioural BRAM port B: one-cycle synchronous read.
    logic [DW-1:0] mem [0:65535];
    always @(posedge clk) begin
        if (we_b) mem[addr_b] <= data_b;
        q_b <= mem[addr_b];
    end

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit            port;   // 0 = VGA, 1 = aux
        logic [DW-1:0] data;
        int            due;    // edge_cnt value when rvalid must be seen
    } exp_t;
    exp_t sb[$];

    // Reference model state
    logic [DW-1:0] shadow [0:65535];
    int            m_starve = 0;
    int            m_miss   = 0;
    logic [AW-1:0] m_addr_b = '0;
    logic [DW-1:0] m_data_b = '0;
    bit            vga_stream = 0;
    bit            aux_stream = 0;
    bit            last_ag = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            while (sb.size() > 0 && sb[0].due < edge_cnt) begin
                chk("missing_rvalid_due", 32'(sb[0].due), 32'(edge_cnt));
                void'(sb.pop_front());
            end
            if (vga_rvalid && aux_rvalid) begin
                chk("both_rvalid", 32'd1, 32'd0);
            end else if (vga_rvalid || aux_rvalid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rvalid_port", {31'd0, aux_rvalid}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rvalid_port", {31'd0, aux_rvalid}, {31'd0, e.port});
                    chk("rdata", aux_rvalid ? aux_rdata : vga_rdata, e.data);
                    chk("rvalid_latency", 32'(edge_cnt), 32'(e.due));
                    $display("rd %s data=%h edge=%0d", aux_rvalid ? "aux" : "vga",
                             aux_rvalid ? aux_rdata : vga_rdata, edge_cnt);
                end
            end
        end
    end

    // One clock cycle: called just after a falling edge with inputs set.
    task automatic step();
        bit st, ev, ea;
        exp_t e;
        #1;
        st = (m_starve == LIMIT);
        ev = vga_req && !(aux_req && st);
        ea = aux_req && (!vga_req || st);
        chk("vga_gnt", {31'd0, vga_gnt}, {31'd0, ev});
        chk("aux_gnt", {31'd0, aux_gnt}, {31'd0, ea});
        if (ev) begin
            e.port = 0; e.data = shadow[vga_addr]; e.due = edge_cnt + 2;
            sb.push_back(e);
            m_addr_b = vga_addr;
        end else if (ea) begin
            m_addr_b = aux_addr;
            m_data_b = aux_wdata;
            if (aux_we) begin
                shadow[aux_addr] = aux_wdata;
            end else begin
                e.port = 1; e.data = shadow[aux_addr]; e.due = edge_cnt + 2;
                sb.push_back(e);
            end
        end
        m_starve = (aux_req && !ea) ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
        if (miss_clr) m_miss = 0;
        else if (vga_req && !ev && m_miss < 255) m_miss++;
        last_ag = ea;
        @(posedge clk);
        #1;
        chk("addr_b", {16'd0, addr_b}, {16'd0, m_addr_b});
        chk("data_b", {16'd0, data_b}, {16'd0, m_data_b});
        chk("we_b", {31'd0, we_b}, {31'd0, ea && aux_we});
        chk("miss_count", {24'd0, miss_count}, 32'(m_miss));
        if (ev) begin
            if (vga_stream) vga_addr = vga_addr + 1'b1;
            else vga_req = 1'b0;
        end
        if (ea) begin
            if (aux_stream) aux_addr = aux_addr + 1'b1;
            else aux_req = 1'b0;
        end
        miss_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((vga_req || aux_req) && n < 50) begin
            step();
            n++;
        end
        chk("idle_timeout", {31'd0, vga_req | aux_req}, 32'd0);
        repeat (3) step();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]    = 16'(i) ^ 16'h5A5A;
            shadow[i] = 16'(i) ^ 16'h5A5A;
        end
        mem[16'h0040] = 16'hBEEF; shadow[16'h0040] = 16'hBEEF;
        mem[16'h0041] = 16'h1234; shadow[16'h0041] = 16'h1234;
        for (int k = 0; k < 8; k++) begin
            mem[16'h0200 + k]    = 16'(k + 1);
            shadow[16'h0200 + k] = 16'(k + 1);
        end

        // Power-on reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_addr_b", {16'd0, addr_b}, 32'd0);
        chk("rst_data_b", {16'd0, data_b}, 32'd0);
        chk("rst_we_b", {31'd0, we_b}, 32'd0);
        chk("rst_rvalid", {30'd0, vga_rvalid, aux_rvalid}, 32'd0);
        chk("rst_miss", {24'd0, miss_count}, 32'd0);
        rst = 1'b0;
        repeat (2) step();

        // Single VGA read, single aux read
        vga_req = 1'b1; vga_addr = 16'h0040;
        wait_idle();
        aux_req = 1'b1; aux_we = 1'b0; aux_addr = 16'h0041;
        wait_idle();

        // Aux write then immediate read of the same address
        aux_req = 1'b1; aux_we = 1'b1; aux_addr = 16'h0100; aux_wdata = 16'hA5A5;
        step();
        aux_req = 1'b1; aux_we = 1'b0; aux_addr = 16'h0100;
        step();
        wait_idle();

        // Contention: continuous VGA, aux raised at cycle 0
        begin
            int ag_cycle = -1;
            vga_stream = 1; vga_req = 1'b1; vga_addr = 16'h0300;
            aux_req = 1'b1; aux_we = 1'b0; aux_addr = 16'h0041;
            for (int i = 0; i < 10; i++) begin
                step();
                if (last_ag && ag_cycle < 0) ag_cycle = i;
            end
            chk("starve_slot", 32'(ag_cycle), 32'd4);
            chk("miss_after_contention", {24'd0, miss_count}, 32'd1);
            vga_stream = 0;
            wait_idle();
        end

        // Interleaved back-to-back reads
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                vga_req = 1'b1; vga_addr = 16'(16'h0200 + i);
            end else begin
                aux_req = 1'b1; aux_we = 1'b0; aux_addr = 16'(16'h0200 + i);
            end
            step();
        end
        wait_idle();

        // Miss counter saturation and clear
        vga_stream = 1; aux_stream = 1;
        vga_req = 1'b1; vga_addr = 16'h1000;
        aux_req = 1'b1; aux_we = 1'b0; aux_addr = 16'h2000;
        repeat (1600) step();
        chk("miss_saturated", {24'd0, miss_count}, 32'hFF);
        for (int i = 0; i < 10; i++) begin
            if (m_starve == LIMIT) begin
                miss_clr = 1'b1;
                step();
                chk("miss_clr_on_denial", {24'd0, miss_count}, 32'd0);
                break;
            end
            step();
        end
        vga_stream = 0; aux_stream = 0;
        wait_idle();

        // Randomised traffic over a small address window to exercise hazards
        for (int i = 0; i < 400; i++) begin
            if (!vga_req && ($urandom % 3 == 0)) begin
                vga_req = 1'b1; vga_addr = 16'($urandom % 16);
            end
            if (!aux_req && ($urandom % 2 == 0)) begin
                aux_req   = 1'b1;
                aux_we    = 1'($urandom % 2);
                aux_addr  = 16'($urandom % 16);
                aux_wdata = 16'($urandom);
            end
            step();
        end
        wait_idle();

        // Reset mid-stream with reads in flight
        vga_stream = 1; vga_req = 1'b1; vga_addr = 16'h0500;
        repeat (5) step();
        #2;
        rst = 1'b1;
        #1;
        sb.delete();
        vga_stream = 0; vga_req = 1'b0; aux_req = 1'b0; miss_clr = 1'b0;
        m_starve = 0; m_miss = 0; m_addr_b = '0; m_data_b = '0;
        chk("midrst_addr_b", {16'd0, addr_b}, 32'd0);
        chk("midrst_we_b", {31'd0, we_b}, 32'd0);
        chk("midrst_rvalid", {30'd0, vga_rvalid, aux_rvalid}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_rvalid", {30'd0, vga_rvalid, aux_rvalid}, 32'd0);
        end
        chk("post_rst_miss", {24'd0, miss_count}, 32'd0);

        // Final drain
        repeat (4) step();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
